// File: rtl/p2_decode_exec_if.sv
// Signal bundle for the p2_decode_exec slice: instruction and register values in,
// decoded class, control word, updated registers, address and ALU result out.
interface p2_decode_exec_if;
  logic [31:0] i;
  logic [4:0]  s0;
  logic [4:0]  s1;
  logic [4:0]  s2;
  logic [2:0]  class3;
  logic [4:0]  cs;
  logic [4:0]  os0;
  logic [4:0]  os1;
  logic [4:0]  os2;
  logic [15:0] ml;
  logic [15:0] aluout;

  modport master (
    output i, s0, s1, s2,
    input  class3, cs, os0, os1, os2, ml, aluout
  );

  modport slave (
    input  i, s0, s1, s2,
    output class3, cs, os0, os1, os2, ml, aluout
  );
endinterface

// File: rtl/p2_decode_exec.sv
// MIPS-subset decode/execute slice: decodes one instruction per clock against $s0-$s2,
// registers class, control word, updated registers, address and ALU result; owns a 64x16 data memory.
module p2_decode_exec (
  input logic             clk,
  input logic             rst,
  p2_decode_exec_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [15:0] r_mem [64];
  logic [2:0]  r_class3;
  logic [4:0]  r_cs;
  logic [4:0]  r_os0;
  logic [4:0]  r_os1;
  logic [4:0]  r_os2;
  logic [15:0] r_ml;
  logic [15:0] r_aluout;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm_sext;
  logic [15:0] w_ra;
  logic [15:0] w_rb;
  logic [15:0] w_ea;
  logic [15:0] w_mem_rd;
  logic [2:0]  w_class3;
  logic [4:0]  w_cs;
  logic [15:0] w_ml;
  logic [15:0] w_alu;
  logic        w_reg_we;
  logic [4:0]  w_reg_idx;
  logic [4:0]  w_reg_val;
  logic        w_mem_we;
  logic [4:0]  w_os0;
  logic [4:0]  w_os1;
  logic [4:0]  w_os2;
  logic        w_unused;

  function automatic logic [15:0] read_reg(input logic [4:0] idx, input logic [4:0] v0,
                                           input logic [4:0] v1, input logic [4:0] v2);
    logic [15:0] val;
    case (idx)
      5'd16:   val = {11'd0, v0};
      5'd17:   val = {11'd0, v1};
      5'd18:   val = {11'd0, v2};
      default: val = 16'd0;
    endcase
    return val;
  endfunction

  assign w_op       = bus.i[31:26];
  assign w_rs       = bus.i[25:21];
  assign w_rt       = bus.i[20:16];
  assign w_rd       = bus.i[15:11];
  assign w_funct    = bus.i[5:0];
  assign w_imm_sext = bus.i[15:0];
  assign w_ra       = read_reg(w_rs, bus.s0, bus.s1, bus.s2);
  assign w_rb       = read_reg(w_rt, bus.s0, bus.s1, bus.s2);
  assign w_ea       = w_ra + w_imm_sext;
  // Combinational read of the array gives lw the pre-edge contents.
  assign w_mem_rd   = r_mem[w_ea[5:0]];
  assign w_unused   = ^{bus.i[10:6], w_mem_rd[15:5]};

  always_comb begin
    w_class3  = 3'b000;
    w_cs      = 5'b00000;
    w_ml      = 16'd0;
    w_alu     = 16'd0;
    w_reg_we  = 1'b0;
    w_reg_idx = 5'd0;
    w_reg_val = 5'd0;
    w_mem_we  = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_class3 = 3'b001;
        w_reg_idx = w_rd;
        w_cs = 5'b10000;
        w_reg_we = 1'b1;
        case (w_funct)
          FN_ADD:  w_alu = w_ra + w_rb;
          FN_SUB:  w_alu = w_ra - w_rb;
          FN_AND:  w_alu = w_ra & w_rb;
          FN_OR:   w_alu = w_ra | w_rb;
          FN_SLT:  w_alu = ($signed(w_ra) < $signed(w_rb)) ? 16'd1 : 16'd0;
          default: begin
            w_cs     = 5'b00000;
            w_reg_we = 1'b0;
          end
        endcase
        w_reg_val = w_alu[4:0];
      end
      OP_LW: begin
        w_class3  = 3'b010;
        w_cs      = 5'b11100;
        w_ml      = w_ea;
        w_alu     = w_ea;
        w_reg_we  = 1'b1;
        w_reg_idx = w_rt;
        w_reg_val = w_mem_rd[4:0];
      end
      OP_SW: begin
        w_class3 = 3'b010;
        w_cs     = 5'b01010;
        w_ml     = w_ea;
        w_alu    = w_ea;
        w_mem_we = 1'b1;
      end
      OP_BEQ: begin
        w_class3 = 3'b010;
        w_cs     = 5'b00001;
        w_ml     = {w_imm_sext[13:0], 2'b00};
        w_alu    = w_ra - w_rb;
      end
      OP_J: begin
        w_class3 = 3'b100;
        w_cs     = 5'b00001;
        w_ml     = {bus.i[13:0], 2'b00};
      end
      default: ;
    endcase
  end

  // Only $s0-$s2 exist here; writes to any other index fall through to the inputs.
  assign w_os0 = (w_reg_we && w_reg_idx == 5'd16) ? w_reg_val : bus.s0;
  assign w_os1 = (w_reg_we && w_reg_idx == 5'd17) ? w_reg_val : bus.s1;
  assign w_os2 = (w_reg_we && w_reg_idx == 5'd18) ? w_reg_val : bus.s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_class3 <= 3'd0;
      r_cs     <= 5'd0;
      r_os0    <= 5'd0;
      r_os1    <= 5'd0;
      r_os2    <= 5'd0;
      r_ml     <= 16'd0;
      r_aluout <= 16'd0;
      for (int k = 0; k < 64; k++) begin
        r_mem[k] <= 16'd0;
      end
    end else begin
      r_class3 <= w_class3;
      r_cs     <= w_cs;
      r_os0    <= w_os0;
      r_os1    <= w_os1;
      r_os2    <= w_os2;
      r_ml     <= w_ml;
      r_aluout <= w_alu;
      if (w_mem_we) begin
        r_mem[w_ea[5:0]] <= w_rb;
      end
    end
  end

  assign bus.class3 = r_class3;
  assign bus.cs     = r_cs;
  assign bus.os0    = r_os0;
  assign bus.os1    = r_os1;
  assign bus.os2    = r_os2;
  assign bus.ml     = r_ml;
  assign bus.aluout = r_aluout;

endmodule

// File: tb/tb_p2_decode_exec.sv
// Self-checking bench for p2_decode_exec: directed cases then random instructions
// compared against an instruction-level reference model with its own memory image.
module tb_p2_decode_exec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;

  p2_decode_exec_if bus ();

  p2_decode_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int model_mem [64];
  int e_class, e_cs, e_os0, e_os1, e_os2, e_ml, e_alu;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int reg_val(input int idx, input int a, input int b, input int c);
    if (idx == 16) return a;
    if (idx == 17) return b;
    if (idx == 18) return c;
    return 0;
  endfunction

  task automatic write_reg(input int idx, input int v);
    if (idx == 16) e_os0 = v;
    else if (idx == 17) e_os1 = v;
    else if (idx == 18) e_os2 = v;
  endtask

  // Architectural effect of one instruction; memory image updated in place.
  task automatic model(input logic [31:0] ins, input int a, input int b, input int c, input bit r);
    int op, rs, rt, rd, fn, simm, tgt, x, y, res, ea;
    e_class = 0; e_cs = 0; e_ml = 0; e_alu = 0;
    if (r) begin
      e_os0 = 0; e_os1 = 0; e_os2 = 0;
      for (int k = 0; k < 64; k++) model_mem[k] = 0;
      return;
    end
    e_os0 = a; e_os1 = b; e_os2 = c;
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
    rd = int'(ins[15:11]); fn = int'(ins[5:0]); tgt = int'(ins[25:0]);
    simm = int'($signed(ins[15:0]));
    x = reg_val(rs, a, b, c);
    y = reg_val(rt, a, b, c);
    ea = (x + simm) & 'hFFFF;
    case (op)
      'h00: begin
        e_class = 1;
        res = -1;
        case (fn)
          'h20: res = x + y;
          'h22: res = (x - y) & 'hFFFF;
          'h24: res = x & y;
          'h25: res = x | y;
          'h2A: res = (x < y) ? 1 : 0;
          default: res = -1;
        endcase
        if (res >= 0) begin
          e_cs = 'b10000;
          e_alu = res;
          write_reg(rd, res % 32);
        end
      end
      'h23: begin
        e_class = 2; e_cs = 'b11100; e_ml = ea; e_alu = ea;
        write_reg(rt, model_mem[ea % 64] % 32);
      end
      'h2B: begin
        e_class = 2; e_cs = 'b01010; e_ml = ea; e_alu = ea;
        model_mem[ea % 64] = y;
      end
      'h04: begin
        e_class = 2; e_cs = 'b00001;
        e_alu = (x - y) & 'hFFFF;
        e_ml = (simm * 4) & 'hFFFF;
      end
      'h02: begin
        e_class = 4; e_cs = 'b00001;
        e_ml = (tgt * 4) & 'hFFFF;
      end
      default: ;
    endcase
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input int a, input int b,
                      input int c, input bit r);
    rst = r;
    bus.i = ins;
    bus.s0 = 5'(a);
    bus.s1 = 5'(b);
    bus.s2 = 5'(c);
    model(ins, a, b, c, r);
    @(posedge clk);
    #1;
    check_val({tag, "_class3"}, 32'(bus.class3), e_class);
    check_val({tag, "_cs"},     32'(bus.cs),     e_cs);
    check_val({tag, "_os0"},    32'(bus.os0),    e_os0);
    check_val({tag, "_os1"},    32'(bus.os1),    e_os1);
    check_val({tag, "_os2"},    32'(bus.os2),    e_os2);
    check_val({tag, "_ml"},     32'(bus.ml),     e_ml);
    check_val({tag, "_aluout"}, 32'(bus.aluout), e_alu);
  endtask

  function automatic int pick_reg();
    return int'($urandom_range(14, 19));
  endfunction

  initial begin
    logic [31:0] ins;
    int kind;
    logic [5:0] functs [6];
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
    functs[3] = 6'h25; functs[4] = 6'h2A; functs[5] = 6'h21;
    bus.i = '0; bus.s0 = '0; bus.s1 = '0; bus.s2 = '0;
    for (int k = 0; k < 64; k++) model_mem[k] = 0;

    step("reset", 32'h0232_8020, 4, 10, 20, 1'b1);
    step("add", 32'h0232_8020, 4, 10, 20, 1'b0);
    check_val("add_alu_const", 32'(bus.aluout), 30);
    step("lw0", 32'h8E30_0020, 4, 10, 20, 1'b0);
    check_val("lw0_ml_const", 32'(bus.ml), 42);
    step("sw", 32'hAE30_0020, 4, 10, 20, 1'b0);
    step("lw1", 32'h8E30_0020, 9, 10, 20, 1'b0);
    check_val("lw1_os0_const", 32'(bus.os0), 4);
    step("beq", 32'h1211_00C8, 4, 10, 20, 1'b0);
    check_val("beq_alu_const", 32'(bus.aluout), 65530);
    check_val("beq_ml_const", 32'(bus.ml), 800);
    step("j", 32'h0800_03E8, 3, 5, 7, 1'b0);
    check_val("j_ml_const", 32'(bus.ml), 4000);
    step("unsup", 32'hFC00_0000, 3, 5, 7, 1'b0);
    step("sw_pre", 32'hAE30_0020, 6, 10, 20, 1'b0);
    step("sw_rst", 32'hAE30_0020, 7, 10, 20, 1'b1);
    step("lw_post", 32'h8E30_0020, 1, 10, 20, 1'b0);
    check_val("lw_post_os0_const", 32'(bus.os0), 0);
    step("slt_neg", {6'h00, 5'd16, 5'd17, 5'd18, 5'd0, 6'h2A}, 9, 3, 1, 1'b0);

    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 6));
      ins = $urandom;
      case (kind)
        0: ins = {6'h00, 5'(pick_reg()), 5'(pick_reg()), 5'(pick_reg()), 5'd0,
                  functs[$urandom_range(0, 5)]};
        1: ins = {6'h23, 5'(pick_reg()), 5'(pick_reg()), 16'($urandom_range(0, 40) - 20)};
        2: ins = {6'h2B, 5'(pick_reg()), 5'(pick_reg()), 16'($urandom_range(0, 40) - 20)};
        3: ins = {6'h04, 5'(pick_reg()), 5'(pick_reg()), 16'($urandom)};
        4: ins = {6'h02, ins[25:0]};
        5: ins = {6'h23, 5'(pick_reg()), 5'(pick_reg()), 16'($urandom)};
        default: ;
      endcase
      step("rand", ins, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
